mem_arb_ctrl: RTL

- Unified, parametrised memory controller: one single-ported word RAM shared by two requesters.
  - Instruction-fetch port: read-only.
  - Data port: read/write.
- Successor to the fixed zero-latency instruction/data memory pair in the processor top level.
- Adds request/acknowledge handshakes, configurable wait states, arbitration and address wrap.
- Sits between the processor core and storage, so multi-cycle memories can be modelled.

---
 rtl/mem_arb_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arb_ctrl.sv
// Shared single-port word RAM with an instruction-fetch read port and a data read/write port.
// Optional MEM_ROUND_ROBIN_EN: alternate grants under contention instead of fixed data priority.
module mem_arb_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic                    gnt_d_r;
    logic                    we_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [DATA_W-1:0]       wdata_r;
    logic                    i_ack_r, d_ack_r, busy_r;
    logic [DATA_W-1:0]       i_rdata_r, d_rdata_r;

    logic                    accept_s, enter_ack_s, pick_d_s;
    logic                    cur_d_s, cur_we_s, wr_en_s;
    logic [DEPTH_LOG2-1:0]   cur_idx_s;
    logic [DATA_W-1:0]       cur_wdata_s;
    logic                    unused_addr_s;

    logic [DATA_W-1:0]       mem_r [DEPTH];

    assign unused_addr_s = ^{i_addr[1:0], i_addr[31:DEPTH_LOG2+2],
                             d_addr[1:0], d_addr[31:DEPTH_LOG2+2]};

`ifdef MEM_ROUND_ROBIN_EN
    logic last_d_r;

    // Contention goes to whichever port was not served last.
    always_comb begin
        if (i_req && d_req) begin
            pick_d_s = !last_d_r;
        end else begin
            pick_d_s = d_req;
        end
    end

    // Last served port; resets to data so the first contest favours fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d_r <= 1'b1;
        end else if (accept_s) begin
            last_d_r <= pick_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    // Fixed priority: the data port always wins.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // Next-state logic for the IDLE/WAIT/ACK sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        accept_s    = 1'b0;
        enter_ack_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    accept_s = 1'b1;
                    cnt_s    = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_s     = ST_ACK;
                        enter_ack_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s     = ST_ACK;
                    enter_ack_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // With zero wait the commit edge is also the acceptance edge, so live inputs bypass the latches.
    always_comb begin
        if (accept_s) begin
            cur_d_s     = pick_d_s;
            cur_we_s    = pick_d_s && d_we;
            cur_idx_s   = pick_d_s ? d_addr[DEPTH_LOG2+1:2] : i_addr[DEPTH_LOG2+1:2];
            cur_wdata_s = d_wdata;
        end else begin
            cur_d_s     = gnt_d_r;
            cur_we_s    = we_r;
            cur_idx_s   = idx_r;
            cur_wdata_s = wdata_r;
        end
        wr_en_s = enter_ack_s && cur_d_s && cur_we_s;
    end

    // Sequencer state, latched request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            gnt_d_r   <= 1'b0;
            we_r      <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= '0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            busy_r    <= 1'b0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            i_ack_r <= enter_ack_s && !cur_d_s;
            d_ack_r <= enter_ack_s && cur_d_s;
            busy_r  <= (state_s != ST_IDLE);
            if (accept_s) begin
                gnt_d_r <= pick_d_s;
                we_r    <= pick_d_s && d_we;
                idx_r   <= cur_idx_s;
                wdata_r <= d_wdata;
            end else begin
                gnt_d_r <= gnt_d_r;
                we_r    <= we_r;
                idx_r   <= idx_r;
                wdata_r <= wdata_r;
            end
            if (enter_ack_s && !cur_d_s) begin
                i_rdata_r <= mem_r[cur_idx_s];
            end else begin
                i_rdata_r <= i_rdata_r;
            end
            if (enter_ack_s && cur_d_s && !cur_we_s) begin
                d_rdata_r <= mem_r[cur_idx_s];
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // Storage array: deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[cur_idx_s] <= cur_wdata_s;
        end
    end

    assign i_ack   = i_ack_r;
    assign d_ack   = d_ack_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
    assign busy    = busy_r;

endmodule
